uart_fifo_controller: RTL and testbench

UART_FIFO_CONTROLLER -- requirements
Module: uart_fifo_controller

---
 rtl/uart_fifo_controller.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_controller.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_controller.sv
// Bridges byte streams to an AXI UART Lite over AXI4-Lite: polls STAT, drains RX into a local
// buffer, feeds TX from a local buffer, retries failed responses and counts dropped transfers.
module uart_fifo_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'h4060_0000,
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // AXI4-Lite master
  output logic                     AXI_AWVALID,
  input  logic                     AXI_AWREADY,
  output logic [31:0]              AXI_AWADDR,
  output logic [2:0]               AXI_AWPROT,
  output logic                     AXI_WVALID,
  input  logic                     AXI_WREADY,
  output logic [31:0]              AXI_WDATA,
  output logic [3:0]               AXI_WSTRB,
  input  logic                     AXI_BVALID,
  output logic                     AXI_BREADY,
  input  logic [1:0]               AXI_BRESP,
  output logic                     AXI_ARVALID,
  input  logic                     AXI_ARREADY,
  output logic [31:0]              AXI_ARADDR,
  output logic [2:0]               AXI_ARPROT,
  input  logic                     AXI_RVALID,
  output logic                     AXI_RREADY,
  input  logic [31:0]              AXI_RDATA,
  input  logic [1:0]               AXI_RRESP,
  // Byte streams
  input  logic [7:0]               UART_WRITE_TDATA,
  input  logic                     UART_WRITE_TVALID,
  output logic                     UART_WRITE_TREADY,
  output logic [7:0]               UART_READ_TDATA,
  output logic                     UART_READ_TVALID,
  input  logic                     UART_READ_TREADY,
  // Status
  output logic [TX_DEPTH_LOG2:0]   TX_LEVEL,
  output logic [RX_DEPTH_LOG2:0]   RX_LEVEL,
  output logic [7:0]               ERR_COUNT
);

  localparam int unsigned TxDepth = 2 ** TX_DEPTH_LOG2;
  localparam int unsigned RxDepth = 2 ** RX_DEPTH_LOG2;
  localparam int unsigned RetryW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle,
    StStatAr,
    StStatR,
    StRxAr,
    StRxR,
    StTxAw,
    StTxB
  } state_t;

  state_t              state_q, state_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [7:0]          err_count_q, err_count_d;

  // ---------------------------------------------------------------------------------------------
  // TX buffer
  // ---------------------------------------------------------------------------------------------
  logic [7:0]               tx_mem [TxDepth];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TX_DEPTH_LOG2:0]   tx_level_q;
  logic                     tx_push, tx_pop, tx_full, tx_empty;

  // Level reaches exactly 2**LOG2 only when full, so the MSB alone flags it.
  assign tx_full           = tx_level_q[TX_DEPTH_LOG2];
  assign tx_empty          = (tx_level_q == '0);
  assign UART_WRITE_TREADY = !tx_full;
  assign tx_push           = UART_WRITE_TVALID && UART_WRITE_TREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      if (tx_push && !tx_pop) begin
        tx_level_q <= tx_level_q + 1'b1;
      end else if (!tx_push && tx_pop) begin
        tx_level_q <= tx_level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= UART_WRITE_TDATA;
  end

  // ---------------------------------------------------------------------------------------------
  // RX buffer (first-word-fall-through)
  // ---------------------------------------------------------------------------------------------
  logic [7:0]               rx_mem [RxDepth];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RX_DEPTH_LOG2:0]   rx_level_q;
  logic                     rx_push, rx_pop, rx_full;

  assign rx_full          = rx_level_q[RX_DEPTH_LOG2];
  assign UART_READ_TVALID = (rx_level_q != '0);
  assign UART_READ_TDATA  = rx_mem[rx_rd_ptr_q];
  assign rx_pop           = UART_READ_TVALID && UART_READ_TREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      if (rx_push && !rx_pop) begin
        rx_level_q <= rx_level_q + 1'b1;
      end else if (!rx_push && rx_pop) begin
        rx_level_q <= rx_level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= AXI_RDATA[7:0];
  end

  // ---------------------------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------------------------
  logic rresp_ok, bresp_ok, retry_exhausted;
  logic unused_rdata;

  // EXOKAY is treated as success; only SLVERR/DECERR (bit 1 set) are failures.
  assign rresp_ok        = !AXI_RRESP[1];
  assign bresp_ok        = !AXI_BRESP[1];
  assign retry_exhausted = (retry_q == MaxRetry);
  assign unused_rdata    = ^AXI_RDATA[31:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      retry_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    err_count_d = err_count_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    unique case (state_q)
      StIdle: begin
        retry_d = '0;
        state_d = StStatAr;
      end
      StStatAr: begin
        if (AXI_ARREADY) state_d = StStatR;
      end
      StStatR: begin
        if (AXI_RVALID) begin
          if (rresp_ok) begin
            retry_d = '0;
            // RX wins each poll; TX only when RX has nothing or nowhere to go.
            if (AXI_RDATA[0] && !rx_full) begin
              state_d = StRxAr;
            end else if (!AXI_RDATA[3] && !tx_empty) begin
              state_d = StTxAw;
            end else begin
              state_d = StIdle;
            end
          end else if (retry_exhausted) begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 1'b1;
            state_d = StIdle;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StStatAr;
          end
        end
      end
      StRxAr: begin
        if (AXI_ARREADY) state_d = StRxR;
      end
      StRxR: begin
        if (AXI_RVALID) begin
          if (rresp_ok) begin
            rx_push = 1'b1;
            state_d = StIdle;
          end else if (retry_exhausted) begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 1'b1;
            state_d = StIdle;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StRxAr;
          end
        end
      end
      StTxAw: begin
        aw_done_d = aw_done_q || AXI_AWREADY;
        w_done_d  = w_done_q || AXI_WREADY;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StTxB;
        end
      end
      StTxB: begin
        if (AXI_BVALID) begin
          if (bresp_ok) begin
            tx_pop  = 1'b1;
            state_d = StIdle;
          end else if (retry_exhausted) begin
            tx_pop  = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 1'b1;
            state_d = StIdle;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StTxAw;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    AXI_ARVALID = 1'b0;
    AXI_ARADDR  = BASE_ADDR + 32'h8;
    AXI_RREADY  = 1'b0;
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    AXI_BREADY  = 1'b0;
    unique case (state_q)
      StStatAr: AXI_ARVALID = 1'b1;
      StStatR:  AXI_RREADY  = 1'b1;
      StRxAr: begin
        AXI_ARVALID = 1'b1;
        AXI_ARADDR  = BASE_ADDR;
      end
      StRxR:    AXI_RREADY  = 1'b1;
      StTxAw: begin
        AXI_AWVALID = !aw_done_q;
        AXI_WVALID  = !w_done_q;
      end
      StTxB:    AXI_BREADY  = 1'b1;
      default: ;
    endcase
  end

  // Head byte cannot change while a write is in flight: it is popped only on completion.
  assign AXI_AWADDR = BASE_ADDR + 32'h4;
  assign AXI_AWPROT = 3'b000;
  assign AXI_ARPROT = 3'b000;
  assign AXI_WSTRB  = 4'b0001;
  assign AXI_WDATA  = {24'h0, tx_mem[tx_rd_ptr_q]};

  assign TX_LEVEL  = tx_level_q;
  assign RX_LEVEL  = rx_level_q;
  assign ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller with a small reactive AXI UART Lite slave model.
module tb_uart_fifo_controller;

  localparam logic [31:0] BASE = 32'h4060_0000;

  logic        clk, rst_n;
  logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY, AXI_BVALID, AXI_BREADY;
  logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
  logic [2:0]  AXI_AWPROT, AXI_ARPROT;
  logic [3:0]  AXI_WSTRB;
  logic [1:0]  AXI_BRESP, AXI_RRESP;
  logic        AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
  logic [7:0]  tx_data, rd_data;
  logic        tx_valid, tx_ready, rd_valid, rx_ready;
  logic [4:0]  tx_level, rx_level;
  logic [7:0]  err_count;

  // Slave model controls and logs
  logic [31:0] stat_val;
  logic [7:0]  rx_byte;
  logic        awready_en, wready_en, bhold;
  logic [1:0]  bresp_q [$];
  logic [7:0]  w_log [$];
  logic [31:0] ar_log [$];
  int          aw_count = 0, stat_reads = 0, rx_reads = 0, bad_proto = 0;
  logic        aw_got, w_got, prev_arwait, prev_awwait;
  logic [31:0] prev_araddr, prev_awaddr;

  int checks = 0;
  int errors = 0;

  uart_fifo_controller #(
    .BASE_ADDR    (BASE),
    .TX_DEPTH_LOG2(4),
    .RX_DEPTH_LOG2(4),
    .MAX_RETRY    (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .AXI_AWVALID      (AXI_AWVALID),
    .AXI_AWREADY      (AXI_AWREADY),
    .AXI_AWADDR       (AXI_AWADDR),
    .AXI_AWPROT       (AXI_AWPROT),
    .AXI_WVALID       (AXI_WVALID),
    .AXI_WREADY       (AXI_WREADY),
    .AXI_WDATA        (AXI_WDATA),
    .AXI_WSTRB        (AXI_WSTRB),
    .AXI_BVALID       (AXI_BVALID),
    .AXI_BREADY       (AXI_BREADY),
    .AXI_BRESP        (AXI_BRESP),
    .AXI_ARVALID      (AXI_ARVALID),
    .AXI_ARREADY      (AXI_ARREADY),
    .AXI_ARADDR       (AXI_ARADDR),
    .AXI_ARPROT       (AXI_ARPROT),
    .AXI_RVALID       (AXI_RVALID),
    .AXI_RREADY       (AXI_RREADY),
    .AXI_RDATA        (AXI_RDATA),
    .AXI_RRESP        (AXI_RRESP),
    .UART_WRITE_TDATA (tx_data),
    .UART_WRITE_TVALID(tx_valid),
    .UART_WRITE_TREADY(tx_ready),
    .UART_READ_TDATA  (rd_data),
    .UART_READ_TVALID (rd_valid),
    .UART_READ_TREADY (rx_ready),
    .TX_LEVEL         (tx_level),
    .RX_LEVEL         (rx_level),
    .ERR_COUNT        (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign AXI_ARREADY = 1'b1;
  assign AXI_AWREADY = awready_en;
  assign AXI_WREADY  = wready_en;
  assign AXI_RRESP   = 2'b00;

  // Reactive slave: one-cycle read latency, write response after both AW and W accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AXI_RVALID  <= 1'b0;
      AXI_RDATA   <= '0;
      AXI_BVALID  <= 1'b0;
      AXI_BRESP   <= 2'b00;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      prev_arwait <= 1'b0;
      prev_awwait <= 1'b0;
      prev_araddr <= '0;
      prev_awaddr <= '0;
    end else begin
      if (prev_arwait && (!AXI_ARVALID || AXI_ARADDR != prev_araddr)) bad_proto <= bad_proto + 1;
      if (prev_awwait && (!AXI_AWVALID || AXI_AWADDR != prev_awaddr)) bad_proto <= bad_proto + 1;
      prev_arwait <= AXI_ARVALID && !AXI_ARREADY;
      prev_awwait <= AXI_AWVALID && !AXI_AWREADY;
      prev_araddr <= AXI_ARADDR;
      prev_awaddr <= AXI_AWADDR;
      if (AXI_ARVALID && AXI_ARREADY) begin
        ar_log.push_back(AXI_ARADDR);
        AXI_RVALID <= 1'b1;
        if (AXI_ARPROT != 3'b000) bad_proto <= bad_proto + 1;
        if (AXI_ARADDR == BASE + 32'h8) begin
          AXI_RDATA  <= stat_val;
          stat_reads <= stat_reads + 1;
        end else begin
          AXI_RDATA <= {24'h123456, rx_byte};
          rx_reads  <= rx_reads + 1;
          if (AXI_ARADDR != BASE) bad_proto <= bad_proto + 1;
        end
      end else if (AXI_RVALID && AXI_RREADY) begin
        AXI_RVALID <= 1'b0;
      end
      if (AXI_AWVALID && AXI_AWREADY) begin
        aw_got   <= 1'b1;
        aw_count <= aw_count + 1;
        if (AXI_AWADDR != BASE + 32'h4 || AXI_AWPROT != 3'b000) bad_proto <= bad_proto + 1;
      end
      if (AXI_WVALID && AXI_WREADY) begin
        w_got <= 1'b1;
        w_log.push_back(AXI_WDATA[7:0]);
        if (AXI_WSTRB != 4'b0001 || AXI_WDATA[31:8] != 24'h0) bad_proto <= bad_proto + 1;
      end
      if (aw_got && w_got && !AXI_BVALID && !bhold) begin
        AXI_BVALID <= 1'b1;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
        if (bresp_q.size() > 0) AXI_BRESP <= bresp_q.pop_front();
        else                    AXI_BRESP <= 2'b00;
      end else if (AXI_BVALID && AXI_BREADY) begin
        AXI_BVALID <= 1'b0;
      end
    end
  end

  // Change the status word and let any poll already in flight complete.
  task automatic set_stat(input logic [31:0] v);
    stat_val = v;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_empty(input int limit);
    int n = 0;
    while (tx_level != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n = 0;
    @(negedge clk);
    checks++;
    if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY} !== 5'b0) begin
      errors++;
      $display("FAIL reset_valids got %b want 00000",
               {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY});
    end
    checks++;
    if (tx_level !== 5'd0 || rx_level !== 5'd0 || rd_valid !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got tx=%0d rx=%0d rvalid=%b err=%0d want 0 0 0 0",
               tx_level, rx_level, rd_valid, err_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (ar_log.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ar_log.size() == 0 || ar_log[0] !== BASE + 32'h8) begin
      errors++;
      $display("FAIL reset_first_ar got size=%0d addr=%h want %h", ar_log.size(),
               (ar_log.size() > 0) ? ar_log[0] : 32'h0, BASE + 32'h8);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready got %b want 1", tx_ready);
    end
  endtask

  task automatic test_tx_basic();
    set_stat(32'h08);
    w_log.delete();
    push_byte(8'h41);
    push_byte(8'h42);
    checks++;
    if (tx_level !== 5'd2) begin
      errors++;
      $display("FAIL tx_basic_level got %0d want 2", tx_level);
    end
    stat_val = 32'h04;
    wait_tx_empty(300);
    checks++;
    if (w_log.size() != 2 || w_log[0] !== 8'h41 || w_log[1] !== 8'h42) begin
      errors++;
      $display("FAIL tx_basic_data got n=%0d first=%h second=%h want 2 41 42", w_log.size(),
               (w_log.size() > 0) ? w_log[0] : 8'h0, (w_log.size() > 1) ? w_log[1] : 8'h0);
    end
    checks++;
    if (tx_level !== 5'd0) begin
      errors++;
      $display("FAIL tx_basic_drain got %0d want 0", tx_level);
    end
    set_stat(32'h00);
  endtask

  task automatic test_rx_hold();
    int base = rx_reads;
    int n = 0;
    int bad = 0;
    rx_byte  = 8'h5A;
    rx_ready = 1'b0;
    stat_val = 32'h01;
    while (rx_reads == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    stat_val = 32'h00;
    n = 0;
    while (!rd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A || rx_level !== 5'd1) begin
      errors++;
      $display("FAIL rx_first got valid=%b data=%h level=%0d want 1 5a 1", rd_valid, rd_data,
               rx_level);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_data !== 8'h5A || rd_valid !== 1'b1 || rx_level !== 5'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rx_hold got %0d unstable cycles want 0", bad);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++;
    if (rx_level !== 5'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_pop got level=%0d valid=%b want 0 0", rx_level, rd_valid);
    end
  endtask

  task automatic test_tx_full_stat();
    int aw_base, st_base;
    set_stat(32'h08);
    w_log.delete();
    push_byte(8'h10);
    push_byte(8'h11);
    push_byte(8'h12);
    aw_base = aw_count;
    st_base = stat_reads;
    repeat (30) @(negedge clk);
    checks++;
    if (aw_count != aw_base || stat_reads < st_base + 3 || tx_level !== 5'd3) begin
      errors++;
      $display("FAIL tx_stat_full got aw=%0d polls=%0d level=%0d want 0 >=3 3",
               aw_count - aw_base, stat_reads - st_base, tx_level);
    end
    stat_val = 32'h04;
    wait_tx_empty(300);
    checks++;
    if (w_log.size() != 3 || w_log[2] !== 8'h12 || tx_level !== 5'd0) begin
      errors++;
      $display("FAIL tx_stat_resume got n=%0d level=%0d want 3 0", w_log.size(), tx_level);
    end
    set_stat(32'h00);
  endtask

  task automatic test_retry();
    int aw_base;
    int bad = 0;
    logic [7:0] err_base;
    set_stat(32'h08);
    push_byte(8'h33);
    w_log.delete();
    aw_base  = aw_count;
    err_base = err_count;
    bresp_q  = '{2'b10, 2'b10, 2'b10, 2'b10};
    stat_val = 32'h04;
    wait_tx_empty(400);
    foreach (w_log[i]) if (w_log[i] !== 8'h33) bad++;
    checks++;
    if (aw_count - aw_base != 4 || w_log.size() != 4 || bad != 0) begin
      errors++;
      $display("FAIL retry_drop_attempts got aw=%0d w=%0d baddata=%0d want 4 4 0",
               aw_count - aw_base, w_log.size(), bad);
    end
    checks++;
    if (err_count !== err_base + 8'd1 || tx_level !== 5'd0) begin
      errors++;
      $display("FAIL retry_drop_err got err=%0d level=%0d want %0d 0", err_count, tx_level,
               err_base + 8'd1);
    end
    set_stat(32'h08);
    push_byte(8'h33);
    w_log.delete();
    aw_base  = aw_count;
    bresp_q  = '{2'b10, 2'b10};
    stat_val = 32'h04;
    wait_tx_empty(400);
    checks++;
    if (aw_count - aw_base != 3 || w_log.size() != 3 || err_count !== err_base + 8'd1) begin
      errors++;
      $display("FAIL retry_recover got aw=%0d w=%0d err=%0d want 3 3 %0d", aw_count - aw_base,
               w_log.size(), err_count, err_base + 8'd1);
    end
    set_stat(32'h00);
  endtask

  task automatic test_fill_and_simul();
    logic [7:0] exp [$];
    int n;
    int bad = 0;
    set_stat(32'h08);
    w_log.delete();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h80 + 8'(i));
      exp.push_back(8'h80 + 8'(i));
      if (i == 14) begin
        checks++;
        if (tx_ready !== 1'b1 || tx_level !== 5'd15) begin
          errors++;
          $display("FAIL fill_15 got ready=%b level=%0d want 1 15", tx_ready, tx_level);
        end
      end
    end
    checks++;
    if (tx_ready !== 1'b0 || tx_level !== 5'd16) begin
      errors++;
      $display("FAIL fill_16 got ready=%b level=%0d want 0 16", tx_ready, tx_level);
    end
    // Two paced pops: the first frees a slot, the second coincides with a push.
    for (int k = 0; k < 2; k++) begin
      bhold    = 1'b1;
      stat_val = 32'h04;
      n = 0;
      while (!AXI_BREADY && n < 100) begin
        @(negedge clk);
        n++;
      end
      set_stat(32'h08);
      bhold = 1'b0;
      n = 0;
      while (!AXI_BVALID && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (k == 1) begin
        tx_data  = 8'hC0;
        tx_valid = 1'b1;
        exp.push_back(8'hC0);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      checks++;
      if (tx_level !== 5'd15 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL pop_step%0d got level=%0d ready=%b want 15 1", k, tx_level, tx_ready);
      end
    end
    stat_val = 32'h04;
    wait_tx_empty(2000);
    if (w_log.size() != exp.size()) bad++;
    else foreach (exp[i]) if (w_log[i] !== exp[i]) bad++;
    checks++;
    if (bad != 0 || tx_level !== 5'd0) begin
      errors++;
      $display("FAIL fill_order got n=%0d bad=%0d level=%0d want %0d 0 0", w_log.size(), bad,
               tx_level, exp.size());
    end
    set_stat(32'h00);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int aw_base;
    set_stat(32'h08);
    awready_en = 1'b0;
    push_byte(8'h55);
    push_byte(8'h56);
    stat_val = 32'h04;
    while (!AXI_AWVALID && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (AXI_AWVALID !== 1'b1 || AXI_WVALID !== 1'b0 || AXI_WDATA !== 32'h55) begin
      errors++;
      $display("FAIL aw_pending got awv=%b wv=%b wdata=%h want 1 0 00000055", AXI_AWVALID,
               AXI_WVALID, AXI_WDATA);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_valids got %b want 00000",
               {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY});
    end
    checks++;
    if (tx_level !== 5'd0 || err_count !== 8'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got tx=%0d err=%0d rvalid=%b want 0 0 0", tx_level,
               err_count, rd_valid);
    end
    awready_en = 1'b1;
    stat_val   = 32'h00;
    ar_log.delete();
    aw_base = aw_count;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (ar_log.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ar_log.size() == 0 || ar_log[0] !== BASE + 32'h8 || aw_count != aw_base) begin
      errors++;
      $display("FAIL midreset_first got n=%0d addr=%h aw=%0d want >0 %h 0", ar_log.size(),
               (ar_log.size() > 0) ? ar_log[0] : 32'h0, BASE + 32'h8, aw_count - aw_base);
    end
  endtask

  task automatic test_protocol();
    repeat (5) @(negedge clk);
    checks++;
    if (bad_proto != 0) begin
      errors++;
      $display("FAIL protocol got %0d violations want 0", bad_proto);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    rx_ready   = 1'b0;
    stat_val   = 32'h0;
    rx_byte    = 8'h00;
    awready_en = 1'b1;
    wready_en  = 1'b1;
    bhold      = 1'b0;
    test_reset();
    test_tx_basic();
    test_rx_hold();
    test_tx_full_stat();
    test_retry();
    test_fill_and_simul();
    test_reset_mid();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
